// File: rtl/moment_divider_if.sv
// Handshake and operand/result bundle between the flow controller and the
// fixed-point momentum divider. Operands and results are carried as raw bit
// vectors and interpreted as two's-complement fixed-point by both sides.
interface moment_divider_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  div_start;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic [DATA_WIDTH-1:0] quotient;
   logic                  div_valid;
   logic                  div_busy;
   logic                  div_by_zero;
   logic                  div_sat;

   // Controller side: issues requests, consumes results.
   modport master (
      output div_start, dividend, divisor,
      input  quotient, div_valid, div_busy, div_by_zero, div_sat
   );

   // Divider side: consumes requests, produces results.
   modport slave (
      input  div_start, dividend, divisor,
      output quotient, div_valid, div_busy, div_by_zero, div_sat
   );
endinterface

// File: rtl/moment_divider.sv
// Signed fixed-point divider computing velocity = momentum / density.
// Magnitudes are divided with a restoring shift-subtract loop, one quotient
// bit per cycle MSB-first, then the sign is applied and the result clamped
// to the representable range. A zero divisor short-circuits to a saturated
// result without entering the iteration loop.
module moment_divider #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16
) (
   input logic          Clk,
   input logic          Reset,
   moment_divider_if.slave div_if
);

   localparam int ITER  = DATA_WIDTH + FRAC_BITS;
   localparam int CNT_W = $clog2(ITER + 1);

   localparam logic [ITER-1:0]       NEG_LIM = ITER'(1) << (DATA_WIDTH - 1);
   localparam logic [ITER-1:0]       POS_LIM = NEG_LIM - ITER'(1);
   localparam logic [DATA_WIDTH-1:0] MAX_Q   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_Q   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [ITER-1:0]       dvd;        // dividend magnitude, quotient bits shift in at the LSB
   logic [DATA_WIDTH-1:0] dvs;        // divisor magnitude
   logic [DATA_WIDTH-1:0] rem;        // partial remainder, always < dvs
   logic                  sign;
   logic [DATA_WIDTH-1:0] quotient_q;
   logic                  by_zero_q;
   logic                  sat_q;

   logic                  accept;
   logic                  div_zero;
   logic                  last_step;
   logic [DATA_WIDTH-1:0] abs_dividend;
   logic [DATA_WIDTH-1:0] abs_divisor;
   logic [DATA_WIDTH:0]   trial;
   logic                  q_bit;
   logic [DATA_WIDTH-1:0] rem_nxt;
   logic [ITER-1:0]       dvd_nxt;
   logic [DATA_WIDTH-1:0] result;
   logic                  result_sat;

   // A request is taken whenever no division is running; reset has priority.
   assign accept    = div_if.div_start && (state != CALC) && !Reset;
   assign div_zero  = (div_if.divisor == '0);
   assign last_step = (state == CALC) && (cnt == CNT_W'(ITER - 1));

   // Magnitudes are unsigned, so the most negative operand maps to 2^(N-1) without wrapping.
   assign abs_dividend = div_if.dividend[DATA_WIDTH-1] ? -div_if.dividend : div_if.dividend;
   assign abs_divisor  = div_if.divisor[DATA_WIDTH-1]  ? -div_if.divisor  : div_if.divisor;

   // State register.
   always_ff @(posedge Clk) begin
      // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = div_zero ? DONE : CALC;
            else        state_nxt = IDLE;
         end
         CALC:    if (last_step) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are pure functions of the state.
   always_comb begin
      div_if.div_valid = (state == DONE);
      div_if.div_busy  = (state == CALC);
   end

   // One restoring step: shift the next dividend bit into the remainder and subtract if it fits.
   always_comb begin
      trial   = {rem, dvd[ITER-1]};
      q_bit   = (trial >= {1'b0, dvs});
      rem_nxt = q_bit ? (trial[DATA_WIDTH-1:0] - dvs) : trial[DATA_WIDTH-1:0];
      dvd_nxt = {dvd[ITER-2:0], q_bit};
   end

   // Sign application and clamping of the final magnitude.
   always_comb begin
      result     = '0;
      result_sat = 1'b0;
      if (!sign) begin
         result_sat = (dvd_nxt > POS_LIM);
         result     = result_sat ? MAX_Q : dvd_nxt[DATA_WIDTH-1:0];
      end else begin
         result_sat = (dvd_nxt > NEG_LIM);
         result     = result_sat ? MIN_Q : -dvd_nxt[DATA_WIDTH-1:0];
      end
   end

   // Iteration counter and registered result/status, held until the next completion.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt        <= '0;
         quotient_q <= '0;
         by_zero_q  <= 1'b0;
         sat_q      <= 1'b0;
      end else if (accept) begin
         cnt <= '0;
         if (div_zero) begin
            quotient_q <= div_if.dividend[DATA_WIDTH-1] ? MIN_Q : MAX_Q;
            by_zero_q  <= 1'b1;
            sat_q      <= 1'b1;
         end
      end else if (last_step) begin
         quotient_q <= result;
         by_zero_q  <= 1'b0;
         sat_q      <= result_sat;
      end else if (state == CALC) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Operand datapath, loaded on acceptance and stepped while calculating.
   always_ff @(posedge Clk) begin
      // NOTE: no reset here; these registers are fully reloaded on every accepted request before use.
      if (accept) begin
         dvd  <= ITER'(abs_dividend) << FRAC_BITS;
         dvs  <= abs_divisor;
         rem  <= '0;
         sign <= div_if.dividend[DATA_WIDTH-1] ^ div_if.divisor[DATA_WIDTH-1];
      end else if (state == CALC) begin
         dvd <= dvd_nxt;
         rem <= rem_nxt;
      end
   end

   assign div_if.quotient    = quotient_q;
   assign div_if.div_by_zero = by_zero_q;
   assign div_if.div_sat     = sat_q;

endmodule

// File: tb/tb_moment_divider.sv
// Self-checking bench for moment_divider: directed corner cases, abort and
// back-to-back scenarios, then random operands against an arithmetic model.
module tb_moment_divider;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   moment_divider_if dif ();

   moment_divider dut (
      .Clk    (clk),
      .Reset  (reset),
      .div_if (dif)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference: plain integer division of fixed-point magnitudes, then sign and clamp.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic sat, output logic dbz);
      longint ia, ib, ma, mb, mag;
      bit     neg;
      ia = longint'($signed(a));
      ib = longint'($signed(b));
      if (ib == 0) begin
         q   = (ia < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         sat = 1'b1;
         dbz = 1'b1;
         return;
      end
      dbz = 1'b0;
      ma  = (ia < 0) ? -ia : ia;
      mb  = (ib < 0) ? -ib : ib;
      mag = (ma * 65536) / mb;
      neg = (ia < 0) != (ib < 0);
      if (!neg) begin
         sat = (mag > 64'sd2147483647);
         q   = sat ? 32'h7FFF_FFFF : 32'(mag);
      end else begin
         sat = (mag > 64'sd2147483648);
         q   = sat ? 32'h8000_0000 : 32'(-mag);
      end
   endfunction

   // Presents a request for one edge; returns #1 after the accepting edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dif.div_start = 1'b1;
      dif.dividend  = a;
      dif.divisor   = b;
      @(posedge clk);
      #1;
      dif.div_start = 1'b0;
   endtask

   // Counts edges until div_valid; 'already' is the edge count already elapsed. -1 on timeout.
   task automatic wait_valid(input int already, output int lat);
      lat = already;
      if (dif.div_valid) return;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (dif.div_valid) return;
      end
      lat = -1;
   endtask

   task automatic run_and_check(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic sat, input logic dbz,
                                input string tag);
      int lat;
      start_op(a, b);
      if (b != 0) check({tag, " busy"}, 32'(dif.div_busy), 32'd1);
      wait_valid(1, lat);
      check({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'd49);
      check({tag, " quotient"}, dif.quotient, q);
      check({tag, " sat"}, 32'(dif.div_sat), 32'(sat));
      check({tag, " dbz"}, 32'(dif.div_by_zero), 32'(dbz));
      check({tag, " busy done"}, 32'(dif.div_busy), 32'd0);
      @(posedge clk);
      #1;
      check({tag, " valid pulse"}, 32'(dif.div_valid), 32'd0);
      check({tag, " hold"}, dif.quotient, q);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, b, q;
      logic        sat, dbz;
      logic [31:0] qc;
      logic        satc, dbzc;
      int          lat, hits, sel;

      reset         = 1'b1;
      dif.div_start = 1'b0;
      dif.dividend  = '0;
      dif.divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset quotient", dif.quotient, 32'd0);
      check("reset valid", 32'(dif.div_valid), 32'd0);
      check("reset busy", 32'(dif.div_busy), 32'd0);
      check("reset dbz", 32'(dif.div_by_zero), 32'd0);
      check("reset sat", 32'(dif.div_sat), 32'd0);
      reset = 1'b0;

      // Directed cases with hand-derived expectations.
      run_and_check(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 1'b0, "half");
      run_and_check(32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, "neg/pos");
      run_and_check(32'hFFFD_0000, 32'hFFFE_0000, 32'h0001_8000, 1'b0, 1'b0, "neg/neg");
      run_and_check(32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, "zero div pos");
      run_and_check(32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, "zero div neg");
      run_and_check(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, "pos sat");
      run_and_check(32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "minint/-1");
      run_and_check(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, "minint/1");
      run_and_check(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, "neg sat");
      run_and_check(32'h0000_0001, 32'h0003_0000, 32'h0000_0000, 1'b0, 1'b0, "underflow");

      // Start during CALC is ignored; start in the DONE cycle chains immediately.
      start_op(32'h0003_0000, 32'h0002_0000);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      start_op(32'h0001_0000, 32'h0004_0000);
      wait_valid(11, lat);
      check("ignore latency", 32'(lat), 32'd49);
      check("ignore quotient", dif.quotient, 32'h0001_8000);
      ref_div(32'hFFFF_0000, 32'h0003_0000, qc, satc, dbzc);
      dif.div_start = 1'b1;
      dif.dividend  = 32'hFFFF_0000;
      dif.divisor   = 32'h0003_0000;
      @(posedge clk);
      #1;
      dif.div_start = 1'b0;
      check("b2b busy", 32'(dif.div_busy), 32'd1);
      check("b2b hold", dif.quotient, 32'h0001_8000);
      wait_valid(1, lat);
      check("b2b latency", 32'(lat), 32'd49);
      check("b2b quotient", dif.quotient, qc);
      check("b2b sat", 32'(dif.div_sat), 32'(satc));
      @(posedge clk);
      #1;

      // Reset mid-calculation aborts without a completion pulse.
      start_op(32'h0007_0000, 32'h0002_0000);
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      reset         = 1'b1;
      dif.div_start = 1'b1;
      @(posedge clk);
      #1;
      check("abort quotient", dif.quotient, 32'd0);
      check("abort valid", 32'(dif.div_valid), 32'd0);
      check("abort busy", 32'(dif.div_busy), 32'd0);
      check("abort dbz", 32'(dif.div_by_zero), 32'd0);
      check("abort sat", 32'(dif.div_sat), 32'd0);
      reset         = 1'b0;
      dif.div_start = 1'b0;
      hits = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (dif.div_valid || dif.div_busy) hits++;
      end
      check("abort silent", 32'(hits), 32'd0);
      run_and_check(32'h0007_0000, 32'h0002_0000, 32'h0003_8000, 1'b0, 1'b0, "after abort");

      // Random operands against the reference model.
      for (int i = 0; i < 40; i++) begin
         a   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)      b = 32'd0;
         else if (sel < 4)  b = 32'($urandom_range(1, 255));
         else if (sel < 6)  b = {{16{a[31]}}, 16'($urandom)} | 32'h0000_0100;
         else               b = $urandom;
         if (i % 5 == 0)    a = {{17{a[31]}}, a[14:0]};
         ref_div(a, b, q, sat, dbz);
         run_and_check(a, b, q, sat, dbz, $sformatf("rand%0d", i));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         check($sformatf("rand%0d idle hold", i), dif.quotient, q);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
